// File: rtl/axi_4_lite_mst.sv
// AXI4-Lite single-outstanding master: turns one user command into one AXI
// transaction and hands the captured response back on the RSP channel.
`ifndef C_AXI_ADDR_WIDTH
`define C_AXI_ADDR_WIDTH 32
`endif
`ifndef C_AXI_DATA_WIDTH
`define C_AXI_DATA_WIDTH 32
`endif
`ifndef C_AXI_STROBE_WIDTH
`define C_AXI_STROBE_WIDTH 4
`endif

module axi_4_lite_mst #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                           M_AXI_ACLK,
  input  logic                           M_AXI_ARESETN,
  output logic                           M_AXI_AWVALID,
  input  logic                           M_AXI_AWREADY,
  output logic [`C_AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
  output logic [2:0]                     M_AXI_AWPROT,
  output logic                           M_AXI_WVALID,
  input  logic                           M_AXI_WREADY,
  output logic [`C_AXI_DATA_WIDTH-1:0]   M_AXI_WDATA,
  output logic [`C_AXI_STROBE_WIDTH-1:0] M_AXI_WSTRB,
  input  logic                           M_AXI_BVALID,
  output logic                           M_AXI_BREADY,
  input  logic [1:0]                     M_AXI_BRESP,
  output logic                           M_AXI_ARVALID,
  input  logic                           M_AXI_ARREADY,
  output logic [`C_AXI_ADDR_WIDTH-1:0]   M_AXI_ARADDR,
  output logic [2:0]                     M_AXI_ARPROT,
  input  logic                           M_AXI_RVALID,
  output logic                           M_AXI_RREADY,
  input  logic [`C_AXI_DATA_WIDTH-1:0]   M_AXI_RDATA,
  input  logic [1:0]                     M_AXI_RRESP,
  input  logic                           CMD_VALID,
  output logic                           CMD_READY,
  input  logic                           CMD_WRITE,
  input  logic [`C_AXI_ADDR_WIDTH-1:0]   CMD_ADDR,
  input  logic [`C_AXI_DATA_WIDTH-1:0]   CMD_WDATA,
  input  logic [`C_AXI_STROBE_WIDTH-1:0] CMD_WSTRB,
  output logic                           RSP_VALID,
  input  logic                           RSP_READY,
  output logic [`C_AXI_DATA_WIDTH-1:0]   RSP_RDATA,
  output logic [1:0]                     RSP_RESP,
  output logic                           STALL
);
  localparam int AW = `C_AXI_ADDR_WIDTH;
  localparam int DW = `C_AXI_DATA_WIDTH;
  localparam int SW = `C_AXI_STROBE_WIDTH;
  localparam int CW = $clog2(TIMEOUT_CYCLES + 2);
  localparam logic [CW-1:0] TMAX = CW'(TIMEOUT_CYCLES);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_WR      = 3'd1;
  localparam logic [2:0] S_WR_RESP = 3'd2;
  localparam logic [2:0] S_RD_ADDR = 3'd3;
  localparam logic [2:0] S_RD_DATA = 3'd4;
  localparam logic [2:0] S_RSP     = 3'd5;

  logic [2:0]    state_q, state_d;
  logic          awvalid_q, awvalid_d, wvalid_q, wvalid_d, arvalid_q, arvalid_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
  logic [SW-1:0] wstrb_q, wstrb_d;
  logic [1:0]    resp_q, resp_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    state_d   = state_q;
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    arvalid_d = arvalid_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    rdata_d   = rdata_q;
    resp_d    = resp_q;
    case (state_q)
      S_IDLE: if (CMD_VALID) begin
        addr_d  = CMD_ADDR;
        wdata_d = CMD_WDATA;
        wstrb_d = CMD_WSTRB;
        if (CMD_WRITE) begin
          state_d   = S_WR;
          awvalid_d = 1'b1;
          wvalid_d  = 1'b1;
        end else begin
          state_d   = S_RD_ADDR;
          arvalid_d = 1'b1;
        end
      end
      // AW and W retire independently; leave once neither is pending
      S_WR: begin
        if (M_AXI_AWREADY) awvalid_d = 1'b0;
        if (M_AXI_WREADY)  wvalid_d  = 1'b0;
        if (!awvalid_d && !wvalid_d) state_d = S_WR_RESP;
      end
      S_WR_RESP: if (M_AXI_BVALID) begin
        resp_d  = M_AXI_BRESP;
        rdata_d = '0;
        state_d = S_RSP;
      end
      S_RD_ADDR: if (M_AXI_ARREADY) begin
        arvalid_d = 1'b0;
        state_d   = S_RD_DATA;
      end
      S_RD_DATA: if (M_AXI_RVALID) begin
        resp_d  = M_AXI_RRESP;
        rdata_d = M_AXI_RDATA;
        state_d = S_RSP;
      end
      S_RSP: if (RSP_READY) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Wait counter restarts on any state change and parks at the limit
  always_comb begin
    cnt_d = cnt_q;
    if (state_d != state_q) cnt_d = '0;
    else if (cnt_q != TMAX) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge M_AXI_ACLK) begin
    if (!M_AXI_ARESETN) begin
      state_q   <= S_IDLE;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      arvalid_q <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      rdata_q   <= '0;
      resp_q    <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      arvalid_q <= arvalid_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      rdata_q   <= rdata_d;
      resp_q    <= resp_d;
      cnt_q     <= cnt_d;
    end
  end

  assign M_AXI_AWVALID = awvalid_q;
  assign M_AXI_AWADDR  = addr_q;
  assign M_AXI_AWPROT  = 3'b000;
  assign M_AXI_WVALID  = wvalid_q;
  assign M_AXI_WDATA   = wdata_q;
  assign M_AXI_WSTRB   = wstrb_q;
  assign M_AXI_BREADY  = (state_q == S_WR_RESP);
  assign M_AXI_ARVALID = arvalid_q;
  assign M_AXI_ARADDR  = addr_q;
  assign M_AXI_ARPROT  = 3'b000;
  assign M_AXI_RREADY  = (state_q == S_RD_DATA);
  assign CMD_READY     = (state_q == S_IDLE);
  assign RSP_VALID     = (state_q == S_RSP);
  assign RSP_RDATA     = rdata_q;
  assign RSP_RESP      = resp_q;
  assign STALL         = (cnt_q == TMAX);
endmodule
